qinj_pulse_sched: RTL and testbench

- CLK40M-domain scheduler that drives the 8-bit 320 MHz phase-select bus `s` of the pulse generator stage directly downstream of it.
- On an accepted trigger it waits a programmed number of 40 MHz cycles, then emits a programmed number of pulse windows separated by programmed gaps.
- Each pulse window presents the phase mask on `s` for exactly one CLK40M cycle; the downstream stage turns that into 320 MHz-phase pulses.
- Used for charge-injection timing scans.

---
 rtl/qinj_pkg.sv | 22 ++
 rtl/qinj_pulse_sched_if.sv | 46 ++++
 rtl/qinj_downcnt.sv | 27 ++
 rtl/qinj_pulse_sched.sv | 160 ++++++++++++++++
 tb/tb_qinj_pulse_sched.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/qinj_pkg.sv
// Shared types and default sizes for the charge-injection pulse scheduler.
// Optional pulse counter is enabled with the QINJ_PULSE_COUNT_EN macro.
package qinj_pkg;

    localparam int PHASE_W      = 8;
    localparam int DEF_DELAY_W  = 8;
    localparam int DEF_NPULSE_W = 4;
    localparam int DEF_GAP_W    = 8;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2,
        GAP    = 2'd3
    } qinj_state_t;

    function automatic int maxWidth(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/qinj_pulse_sched_if.sv
// Control/status bundle between a trigger source (master) and the scheduler (slave).
// pulseCount/cntClear exist only when QINJ_PULSE_COUNT_EN is defined.
interface qinj_pulse_sched_if #(
    parameter int DELAY_W  = qinj_pkg::DEF_DELAY_W,
    parameter int NPULSE_W = qinj_pkg::DEF_NPULSE_W,
    parameter int GAP_W    = qinj_pkg::DEF_GAP_W
`ifdef QINJ_PULSE_COUNT_EN
   ,parameter int CNT_W    = qinj_pkg::DEF_CNT_W
`endif
) ();
    import qinj_pkg::*;

    logic                enable;
    logic                trig;
    logic [PHASE_W-1:0]  phaseMask;
    logic [DELAY_W-1:0]  delay;
    logic [NPULSE_W-1:0] nPulses;
    logic [GAP_W-1:0]    gap;
    logic [PHASE_W-1:0]  s;
    logic                busy;
    logic                done;
    logic                trigDropped;
`ifdef QINJ_PULSE_COUNT_EN
    logic [CNT_W-1:0]    pulseCount;
    logic                cntClear;

    modport master (
        output enable, trig, phaseMask, delay, nPulses, gap, cntClear,
        input  s, busy, done, trigDropped, pulseCount
    );
    modport slave (
        input  enable, trig, phaseMask, delay, nPulses, gap, cntClear,
        output s, busy, done, trigDropped, pulseCount
    );
`else
    modport master (
        output enable, trig, phaseMask, delay, nPulses, gap,
        input  s, busy, done, trigDropped
    );
    modport slave (
        input  enable, trig, phaseMask, delay, nPulses, gap,
        output s, busy, done, trigDropped
    );
`endif

endinterface

// File: rtl/qinj_downcnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module qinj_downcnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_loadVal,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/qinj_pulse_sched.sv
// CLK40M scheduler driving the 320 MHz phase-select bus with delayed pulse bursts.
// Define QINJ_PULSE_COUNT_EN to add the saturating issued-window counter.
module qinj_pulse_sched
    import qinj_pkg::*;
#(
    parameter int DELAY_W  = DEF_DELAY_W,
    parameter int NPULSE_W = DEF_NPULSE_W,
    parameter int GAP_W    = DEF_GAP_W
`ifdef QINJ_PULSE_COUNT_EN
   ,parameter int CNT_W    = DEF_CNT_W
`endif
) (
    input  logic              CLK40M,
    input  logic              RST,
    qinj_pulse_sched_if.slave bus
);

    localparam int TMR_W = maxWidth(DELAY_W, GAP_W);

    qinj_state_t         r_state;
    logic [PHASE_W-1:0]  r_mask;
    logic [GAP_W-1:0]    r_gap;
    logic [PHASE_W-1:0]  r_s;
    logic                r_busy;
    logic                r_finish;
    logic                r_done;
    logic                r_trigDropped;

    logic                w_tmrLoad;
    logic [TMR_W-1:0]    w_tmrVal;
    logic                w_tmrDec;
    logic                w_tmrZero;
    logic                w_pulLoad;
    logic [NPULSE_W-1:0] w_pulVal;
    logic                w_pulDec;
    logic                w_pulZero;

    // The remaining-pulse counter holds windows still owed after the current one,
    // so a zero flag in ACTIVE marks the final window.
    always_comb begin
        w_tmrLoad = 1'b0;
        w_tmrVal  = '0;
        w_tmrDec  = 1'b0;
        w_pulLoad = 1'b0;
        w_pulVal  = '0;
        w_pulDec  = 1'b0;
        if (bus.enable) begin
            case (r_state)
                IDLE: begin
                    if (bus.trig) begin
                        w_pulLoad = 1'b1;
                        w_pulVal  = (bus.nPulses == '0) ? '0 : bus.nPulses - NPULSE_W'(1);
                        if (bus.delay != '0) begin
                            w_tmrLoad = 1'b1;
                            w_tmrVal  = TMR_W'(bus.delay - DELAY_W'(1));
                        end
                    end
                end
                DELAY, GAP: w_tmrDec = 1'b1;
                ACTIVE: begin
                    if (!w_pulZero) begin
                        w_pulDec = 1'b1;
                        if (r_gap != '0) begin
                            w_tmrLoad = 1'b1;
                            w_tmrVal  = TMR_W'(r_gap - GAP_W'(1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    qinj_downcnt #(.W(TMR_W)) u_timer (
        .i_clk     (CLK40M),
        .i_rst     (RST),
        .i_load    (w_tmrLoad),
        .i_loadVal (w_tmrVal),
        .i_dec     (w_tmrDec),
        .o_zero    (w_tmrZero)
    );

    qinj_downcnt #(.W(NPULSE_W)) u_pulses (
        .i_clk     (CLK40M),
        .i_rst     (RST),
        .i_load    (w_pulLoad),
        .i_loadVal (w_pulVal),
        .i_dec     (w_pulDec),
        .o_zero    (w_pulZero)
    );

    // Outputs are registered from the current state, so the visible window trails
    // the internal ACTIVE cycle by one edge; done trails the return to IDLE likewise.
    always_ff @(posedge CLK40M or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_mask        <= '0;
            r_gap         <= '0;
            r_s           <= '0;
            r_busy        <= 1'b0;
            r_finish      <= 1'b0;
            r_done        <= 1'b0;
            r_trigDropped <= 1'b0;
        end else begin
            r_s           <= (r_state == ACTIVE && bus.enable) ? r_mask : '0;
            r_busy        <= (r_state != IDLE) && bus.enable;
            r_finish      <= (r_state == ACTIVE) && bus.enable && w_pulZero;
            r_done        <= r_finish;
            r_trigDropped <= bus.trig && bus.enable && (r_state != IDLE);
            if (!bus.enable) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.trig) begin
                            r_mask  <= bus.phaseMask;
                            r_gap   <= bus.gap;
                            r_state <= (bus.delay != '0) ? DELAY : ACTIVE;
                        end
                    end
                    DELAY: begin
                        if (w_tmrZero) r_state <= ACTIVE;
                    end
                    ACTIVE: begin
                        if (w_pulZero)          r_state <= IDLE;
                        else if (r_gap != '0)   r_state <= GAP;
                        else                    r_state <= ACTIVE;
                    end
                    GAP: begin
                        if (w_tmrZero) r_state <= ACTIVE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.s           = r_s;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.trigDropped = r_trigDropped;

`ifdef QINJ_PULSE_COUNT_EN
    logic [CNT_W-1:0] r_pulseCount;

    // Counts on the same edge that presents a window; clear beats increment.
    always_ff @(posedge CLK40M or posedge RST) begin
        if (RST) begin
            r_pulseCount <= '0;
        end else if (bus.cntClear) begin
            r_pulseCount <= '0;
        end else if (r_state == ACTIVE && bus.enable && r_pulseCount != '1) begin
            r_pulseCount <= r_pulseCount + CNT_W'(1);
        end
    end

    assign bus.pulseCount = r_pulseCount;
`endif

endmodule

// File: tb/tb_qinj_pulse_sched.sv
// Directed self-checking bench for qinj_pulse_sched; pulseCount checks need QINJ_PULSE_COUNT_EN.
module tb_qinj_pulse_sched;

    logic clk = 1'b0;
    logic rst;
    int   tests    = 0;
    int   failures = 0;

    always #12 clk = ~clk;

`ifdef QINJ_PULSE_COUNT_EN
    qinj_pulse_sched_if #(.DELAY_W(8), .NPULSE_W(4), .GAP_W(8), .CNT_W(4)) bus ();
    qinj_pulse_sched #(.DELAY_W(8), .NPULSE_W(4), .GAP_W(8), .CNT_W(4)) dut (
        .CLK40M (clk),
        .RST    (rst),
        .bus    (bus)
    );
`else
    qinj_pulse_sched_if #(.DELAY_W(8), .NPULSE_W(4), .GAP_W(8)) bus ();
    qinj_pulse_sched #(.DELAY_W(8), .NPULSE_W(4), .GAP_W(8)) dut (
        .CLK40M (clk),
        .RST    (rst),
        .bus    (bus)
    );
`endif

    // One burst per record; cycle numbers count edges after the trigger-sampling edge.
    typedef struct {
        logic [7:0] mask;
        logic [7:0] dly;
        logic [3:0] np;
        logic [7:0] gp;
        int         first;
        int         windows;
        int         period;
        int         doneAt;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Trigger is sampled at the next edge; inputs are then scrambled to prove latching.
    task automatic applyStimulus(input logic [7:0] m, input logic [7:0] d,
                                 input logic [3:0] n, input logic [7:0] g);
        bus.phaseMask = m;
        bus.delay     = d;
        bus.nPulses   = n;
        bus.gap       = g;
        bus.trig      = 1'b1;
        tick();
        bus.trig      = 1'b0;
        bus.phaseMask = ~m;
        bus.delay     = 8'd0;
        bus.nPulses   = 4'd9;
        bus.gap       = 8'd7;
    endtask

    task automatic clearCount();
`ifdef QINJ_PULSE_COUNT_EN
        bus.cntClear = 1'b1;
        tick();
        bus.cntClear = 1'b0;
`else
        tick();
`endif
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] expS;
        int         doneSeen;

        vecs[0] = '{8'h05, 8'd3, 4'd1, 8'd0, 4, 1, 1, 5};
        vecs[1] = '{8'h80, 8'd0, 4'd3, 8'd2, 1, 3, 3, 8};
        vecs[2] = '{8'h3C, 8'd1, 4'd4, 8'd0, 2, 4, 1, 6};
        vecs[3] = '{8'hA5, 8'd2, 4'd0, 8'd1, 3, 1, 2, 4};
        vecs[4] = '{8'h00, 8'd1, 4'd2, 8'd1, 2, 2, 2, 5};
        vecs[5] = '{8'hFF, 8'd5, 4'd2, 8'd3, 6, 2, 4, 11};

        rst           = 1'b1;
        bus.enable    = 1'b1;
        bus.trig      = 1'b0;
        bus.phaseMask = 8'h00;
        bus.delay     = 8'd0;
        bus.nPulses   = 4'd0;
        bus.gap       = 8'd0;
`ifdef QINJ_PULSE_COUNT_EN
        bus.cntClear  = 1'b0;
`endif
        tick();
        tick();
        checkOutput("reset s", bus.s, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset trigDropped", bus.trigDropped, 0);
`ifdef QINJ_PULSE_COUNT_EN
        checkOutput("reset pulseCount", bus.pulseCount, 0);
`endif
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            clearCount();
            applyStimulus(vecs[v].mask, vecs[v].dly, vecs[v].np, vecs[v].gp);
            for (int c = 0; c <= vecs[v].doneAt + 1; c++) begin
                if (c > 0) tick();
                expS = 8'h00;
                if (c >= vecs[v].first && ((c - vecs[v].first) % vecs[v].period) == 0 &&
                    ((c - vecs[v].first) / vecs[v].period) < vecs[v].windows)
                    expS = vecs[v].mask;
                checkOutput($sformatf("vec%0d s c%0d", v, c), bus.s, expS);
                checkOutput($sformatf("vec%0d busy c%0d", v, c), bus.busy,
                            (c >= 1 && c < vecs[v].doneAt) ? 1 : 0);
                checkOutput($sformatf("vec%0d done c%0d", v, c), bus.done,
                            (c == vecs[v].doneAt) ? 1 : 0);
                checkOutput($sformatf("vec%0d trigDropped c%0d", v, c), bus.trigDropped, 0);
            end
`ifdef QINJ_PULSE_COUNT_EN
            checkOutput($sformatf("vec%0d pulseCount", v), bus.pulseCount, vecs[v].windows);
`endif
            tick();
        end

        // Second trigger during DELAY is dropped once and leaves timing alone.
        applyStimulus(8'h05, 8'd3, 4'd1, 8'd0);
        doneSeen = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 2) bus.trig = 1'b0;
            checkOutput($sformatf("busyTrig trigDropped c%0d", c), bus.trigDropped, (c == 2) ? 1 : 0);
            if (c == 4) checkOutput("busyTrig s c4", bus.s, 8'h05);
            if (bus.done) doneSeen++;
            if (c == 1) bus.trig = 1'b1;
        end
        checkOutput("busyTrig done count", doneSeen, 1);

        // Enable dropped during GAP aborts without done.
        clearCount();
        applyStimulus(8'h80, 8'd0, 4'd3, 8'd2);
        tick();
        checkOutput("abort s window1", bus.s, 8'h80);
        bus.enable = 1'b0;
        tick();
        checkOutput("abort s", bus.s, 0);
        checkOutput("abort busy", bus.busy, 0);
        doneSeen = 0;
        for (int c = 3; c <= 9; c++) begin
            tick();
            if (bus.done || bus.s != 8'h00) doneSeen++;
        end
        checkOutput("abort quiet after", doneSeen, 0);
`ifdef QINJ_PULSE_COUNT_EN
        checkOutput("abort pulseCount", bus.pulseCount, 1);
`endif
        bus.enable = 1'b1;
        tick();

        // Reset during an active window clears outputs immediately.
        applyStimulus(8'h3C, 8'd0, 4'd4, 8'd0);
        tick();
        checkOutput("rst s before", bus.s, 8'h3C);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst s immediate", bus.s, 0);
        checkOutput("rst busy immediate", bus.busy, 0);
        #4 rst = 1'b0;
        tick();
        tick();
        checkOutput("rst s after", bus.s, 0);
        checkOutput("rst busy after", bus.busy, 0);

        // A trigger while done is high is accepted.
        applyStimulus(8'h05, 8'd0, 4'd1, 8'd0);
        tick();
        checkOutput("doneTrig s c1", bus.s, 8'h05);
        tick();
        checkOutput("doneTrig done c2", bus.done, 1);
        applyStimulus(8'h11, 8'd0, 4'd0, 8'd0);
        checkOutput("doneTrig trigDropped", bus.trigDropped, 0);
        tick();
        checkOutput("doneTrig second s", bus.s, 8'h11);
        tick();
        checkOutput("doneTrig second done", bus.done, 1);
        tick();

        // Trigger with enable low while idle is ignored silently.
        bus.enable = 1'b0;
        applyStimulus(8'h22, 8'd0, 4'd1, 8'd0);
        tick();
        checkOutput("disabled busy", bus.busy, 0);
        checkOutput("disabled trigDropped", bus.trigDropped, 0);
        tick();
        checkOutput("disabled s", bus.s, 0);
        bus.enable = 1'b1;
        tick();

`ifdef QINJ_PULSE_COUNT_EN
        // 20 windows saturate the 4-bit counter; clear beats a same-edge increment.
        clearCount();
        applyStimulus(8'h01, 8'd0, 4'd15, 8'd0);
        for (int c = 1; c <= 17; c++) tick();
        applyStimulus(8'h01, 8'd0, 4'd5, 8'd0);
        for (int c = 1; c <= 7; c++) tick();
        checkOutput("saturate pulseCount", bus.pulseCount, 15);
        applyStimulus(8'h01, 8'd0, 4'd1, 8'd0);
        bus.cntClear = 1'b1;
        tick();
        bus.cntClear = 1'b0;
        checkOutput("clearWins s", bus.s, 8'h01);
        checkOutput("clearWins pulseCount", bus.pulseCount, 0);
        tick();
        checkOutput("clearWins pulseCount later", bus.pulseCount, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
